core_trace_monitor: RTL and testbench

Synthesizable, parametrised retire-trace monitor that sits beside the core and replaces ad-hoc simulation-only peeking of `pc`/`ir`. It records retired instructions into a circular buffer with a PC-match trigger and post-trigger window, keeps free-running cycle and retire counters, and detects program end (jump-to-self). Captured entries are read back in chronological order through a 1-cycle-latency read port, on silicon or in any bench.

---
 rtl/core_trace_monitor_if.sv | 47 ++++
 rtl/core_trace_monitor.sv | 159 +++++++++++++++
 tb/tb_core_trace_monitor.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/core_trace_monitor_if.sv
// Bundle of retire, trigger, read-port and status signals for core_trace_monitor.
// rd_cycle_o exists only when TRACE_CYCLE_EN is defined.
interface core_trace_monitor_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) ();
  localparam int AW = $clog2(DEPTH);

  logic             valid_i;
  logic [XLEN-1:0]  pc_i;
  logic [31:0]      ir_i;
  logic             arm_i;
  logic             trig_en_i;
  logic [XLEN-1:0]  trig_pc_i;
  logic             rd_en_i;
  logic [AW-1:0]    rd_addr_i;
  logic             rd_valid_o;
  logic [XLEN-1:0]  rd_pc_o;
  logic [31:0]      rd_ir_o;
`ifdef TRACE_CYCLE_EN
  logic [CNT_W-1:0] rd_cycle_o;
`endif
  logic [AW:0]      count_o;
  logic [CNT_W-1:0] cycle_o;
  logic [CNT_W-1:0] retired_o;
  logic [1:0]       state_o;
  logic             halted_o;

  modport master (
    output valid_i, pc_i, ir_i, arm_i, trig_en_i, trig_pc_i, rd_en_i, rd_addr_i,
    input  rd_valid_o, rd_pc_o, rd_ir_o,
`ifdef TRACE_CYCLE_EN
           rd_cycle_o,
`endif
           count_o, cycle_o, retired_o, state_o, halted_o
  );

  modport slave (
    input  valid_i, pc_i, ir_i, arm_i, trig_en_i, trig_pc_i, rd_en_i, rd_addr_i,
    output rd_valid_o, rd_pc_o, rd_ir_o,
`ifdef TRACE_CYCLE_EN
           rd_cycle_o,
`endif
           count_o, cycle_o, retired_o, state_o, halted_o
  );
endinterface

// File: rtl/core_trace_monitor.sv
// Retire-trace monitor: circular capture buffer with PC trigger, post window, counters and
// jump-to-self halt detection. Define TRACE_CYCLE_EN to stamp each entry with cycle_o.
module core_trace_monitor #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int POST_TRIG   = 8,
  parameter int CNT_W       = 32,
  parameter int STALL_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  core_trace_monitor_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  localparam logic [1:0] ST_ARMED = 2'd0;
  localparam logic [1:0] ST_POST  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIG);
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

  logic [1:0]       state;
  logic [AW-1:0]    wrptr;
  logic [AW:0]      count;
  logic [AW-1:0]    post_cnt;
  logic [SW-1:0]    stall_cnt;
  logic             halted;
  logic [XLEN-1:0]  prev_pc;
  logic             prev_valid;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retired_cnt;

  logic [XLEN-1:0]  pc_mem [DEPTH];
  logic [31:0]      ir_mem [DEPTH];
`ifdef TRACE_CYCLE_EN
  logic [CNT_W-1:0] cyc_mem [DEPTH];
`endif

  logic          same_pc;
  logic          record;
  logic          halt_now;
  logic          trig_hit;
  logic [AW-1:0] rd_idx;
  logic          rd_in_range;

  // The first retire of a run counts toward STALL_LIMIT, so the halt fires when the
  // self-retire count is about to reach STALL_LIMIT-1.
  always_comb begin
    same_pc     = prev_valid && (bus.pc_i == prev_pc);
    record      = bus.valid_i && !bus.arm_i && (state != ST_DONE);
    halt_now    = bus.valid_i && !bus.arm_i && same_pc &&
                  ((int'(stall_cnt) + 1) >= (STALL_LIMIT - 1));
    trig_hit    = record && (state == ST_ARMED) && bus.trig_en_i &&
                  (bus.pc_i == bus.trig_pc_i);
    rd_idx      = wrptr - count[AW-1:0] + bus.rd_addr_i;
    rd_in_range = {1'b0, bus.rd_addr_i} < count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_ARMED;
      wrptr      <= '0;
      count      <= '0;
      post_cnt   <= '0;
      stall_cnt  <= '0;
      halted     <= 1'b0;
      prev_pc    <= '0;
      prev_valid <= 1'b0;
    end else begin
      if (bus.valid_i) begin
        prev_pc    <= bus.pc_i;
        prev_valid <= 1'b1;
      end
      if (bus.arm_i) begin
        state     <= ST_ARMED;
        wrptr     <= '0;
        count     <= '0;
        post_cnt  <= '0;
        stall_cnt <= '0;
        halted    <= 1'b0;
      end else begin
        if (bus.valid_i) begin
          if (!same_pc)
            stall_cnt <= '0;
          else if (stall_cnt != STALL_MAX)
            stall_cnt <= stall_cnt + SW'(1);
        end
        if (record) begin
          wrptr <= wrptr + AW'(1);
          if (count != FULL)
            count <= count + (AW+1)'(1);
        end
        // Halt wins over trigger and post-window bookkeeping.
        if (halt_now) begin
          halted <= 1'b1;
          state  <= ST_DONE;
        end else if (trig_hit) begin
          post_cnt <= POST_LOAD;
          state    <= (POST_TRIG == 0) ? ST_DONE : ST_POST;
        end else if (record && (state == ST_POST)) begin
          post_cnt <= post_cnt - AW'(1);
          if (post_cnt == AW'(1))
            state <= ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (record) begin
      pc_mem[wrptr] <= bus.pc_i;
      ir_mem[wrptr] <= bus.ir_i;
`ifdef TRACE_CYCLE_EN
      cyc_mem[wrptr] <= cycle_cnt;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (bus.valid_i)
        retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  // Slots beyond the captured count read as zero so stale contents never leak out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_valid_o <= 1'b0;
      bus.rd_pc_o    <= '0;
      bus.rd_ir_o    <= '0;
`ifdef TRACE_CYCLE_EN
      bus.rd_cycle_o <= '0;
`endif
    end else begin
      bus.rd_valid_o <= bus.rd_en_i;
      if (bus.rd_en_i) begin
        bus.rd_pc_o <= rd_in_range ? pc_mem[rd_idx] : '0;
        bus.rd_ir_o <= rd_in_range ? ir_mem[rd_idx] : '0;
`ifdef TRACE_CYCLE_EN
        bus.rd_cycle_o <= rd_in_range ? cyc_mem[rd_idx] : '0;
`endif
      end
    end
  end

  assign bus.count_o   = count;
  assign bus.cycle_o   = cycle_cnt;
  assign bus.retired_o = retired_cnt;
  assign bus.state_o   = state;
  assign bus.halted_o  = halted;
endmodule

// File: tb/tb_core_trace_monitor.sv
// Directed bench for core_trace_monitor at default parameters; the cycle-stamp
// scenario runs only when TRACE_CYCLE_EN is defined.
module tb_core_trace_monitor;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  core_trace_monitor_if #(.XLEN(32), .DEPTH(16), .CNT_W(32)) bus ();

  core_trace_monitor #(
    .XLEN(32), .DEPTH(16), .POST_TRIG(8), .CNT_W(32), .STALL_LIMIT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                               input logic arm);
    bus.valid_i = v;
    bus.pc_i    = pc;
    bus.ir_i    = ir;
    bus.arm_i   = arm;
    step();
    bus.valid_i = 1'b0;
    bus.arm_i   = 1'b0;
  endtask

  task automatic readEntry(input logic [3:0] addr, output logic [31:0] pc,
                           output logic [31:0] ir, output logic v);
    bus.rd_en_i   = 1'b1;
    bus.rd_addr_i = addr;
    step();
    bus.rd_en_i = 1'b0;
    pc = bus.rd_pc_o;
    ir = bus.rd_ir_o;
    v  = bus.rd_valid_o;
  endtask

  task automatic doReset();
    bus.valid_i   = 1'b0;
    bus.arm_i     = 1'b0;
    bus.rd_en_i   = 1'b0;
    bus.trig_en_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] pc, ir;
    logic        v;
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h10 + 32'(4*i), 32'hA0 + 32'(i), 1'b0);
    readEntry(4'd0, pc, ir, v);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.count_o !== 5'd0) begin bad++; $display("[TB] FAIL rst_count got=%0d want=0", bus.count_o); end
    total++; if (bus.cycle_o !== 32'd0) begin bad++; $display("[TB] FAIL rst_cycle got=%0d want=0", bus.cycle_o); end
    total++; if (bus.retired_o !== 32'd0) begin bad++; $display("[TB] FAIL rst_retired got=%0d want=0", bus.retired_o); end
    total++; if (bus.state_o !== 2'd0 || bus.halted_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_state got=%0d/%0b want=0/0", bus.state_o, bus.halted_o); end
    total++; if (bus.rd_valid_o !== 1'b0 || bus.rd_pc_o !== 32'd0 || bus.rd_ir_o !== 32'd0) begin bad++; $display("[TB] FAIL rst_rd got=%0b/%h/%h want=0/0/0", bus.rd_valid_o, bus.rd_pc_o, bus.rd_ir_o); end
    rst = 1'b0;
    applyStimulus(1'b1, 32'h0, 32'hDEAD0001, 1'b0);
    total++; if (bus.count_o !== 5'd1) begin bad++; $display("[TB] FAIL post_rst_count got=%0d want=1", bus.count_o); end
    readEntry(4'd0, pc, ir, v);
    total++; if (v !== 1'b1 || pc !== 32'h0 || ir !== 32'hDEAD0001) begin bad++; $display("[TB] FAIL post_rst_entry0 got=%0b/%h/%h want=1/0/dead0001", v, pc, ir); end
    readEntry(4'd1, pc, ir, v);
    total++; if (v !== 1'b1 || pc !== 32'h0 || ir !== 32'h0) begin bad++; $display("[TB] FAIL unused_slot got=%0b/%h/%h want=1/0/0", v, pc, ir); end
  endtask

  task automatic test_wrap_and_back_to_back();
    logic [31:0] pc0, pc15, ir0, c0;
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'(4*i), 32'h1000 + 32'(i), 1'b0);
    total++; if (bus.count_o !== 5'd16) begin bad++; $display("[TB] FAIL wrap_count got=%0d want=16", bus.count_o); end
    total++; if (bus.retired_o !== 32'd20) begin bad++; $display("[TB] FAIL wrap_retired got=%0d want=20", bus.retired_o); end
    bus.rd_en_i = 1'b1;
    bus.rd_addr_i = 4'd0;
    step();
    pc0 = bus.rd_pc_o;
    ir0 = bus.rd_ir_o;
    total++; if (bus.rd_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_valid0 got=%0b want=1", bus.rd_valid_o); end
    bus.rd_addr_i = 4'd15;
    step();
    pc15 = bus.rd_pc_o;
    total++; if (bus.rd_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_valid1 got=%0b want=1", bus.rd_valid_o); end
    bus.rd_en_i = 1'b0;
    step();
    total++; if (bus.rd_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_valid_drop got=%0b want=0", bus.rd_valid_o); end
    total++; if (pc0 !== 32'h10 || ir0 !== 32'h1004) begin bad++; $display("[TB] FAIL wrap_oldest got=%h/%h want=10/1004", pc0, ir0); end
    total++; if (pc15 !== 32'h4C) begin bad++; $display("[TB] FAIL wrap_newest got=%h want=4c", pc15); end
    c0 = bus.cycle_o;
    for (int i = 0; i < 7; i++) step();
    total++; if (bus.cycle_o !== c0 + 32'd7) begin bad++; $display("[TB] FAIL cycle_run got=%0d want=%0d", bus.cycle_o, c0 + 32'd7); end
  endtask

  task automatic test_trigger();
    logic [31:0] pc, ir;
    logic        v;
    doReset();
    bus.trig_en_i = 1'b1;
    bus.trig_pc_i = 32'h20;
    for (int i = 0; i <= 16; i++) begin
      applyStimulus(1'b1, 32'(4*i), 32'h2000 + 32'(i), 1'b0);
      if (i == 8) begin
        total++; if (bus.state_o !== 2'd1) begin bad++; $display("[TB] FAIL trig_post got=%0d want=1", bus.state_o); end
      end
      if (i == 15) begin
        total++; if (bus.state_o !== 2'd1) begin bad++; $display("[TB] FAIL trig_still_post got=%0d want=1", bus.state_o); end
      end
    end
    total++; if (bus.state_o !== 2'd2) begin bad++; $display("[TB] FAIL trig_done got=%0d want=2", bus.state_o); end
    applyStimulus(1'b1, 32'h44, 32'h2011, 1'b0);
    applyStimulus(1'b1, 32'h20, 32'h2012, 1'b0);
    total++; if (bus.count_o !== 5'd16 || bus.state_o !== 2'd2) begin bad++; $display("[TB] FAIL trig_frozen got=%0d/%0d want=16/2", bus.count_o, bus.state_o); end
    total++; if (bus.retired_o !== 32'd19) begin bad++; $display("[TB] FAIL trig_retired got=%0d want=19", bus.retired_o); end
    readEntry(4'd15, pc, ir, v);
    total++; if (pc !== 32'h40 || ir !== 32'h2010) begin bad++; $display("[TB] FAIL trig_addr15 got=%h/%h want=40/2010", pc, ir); end
    readEntry(4'd7, pc, ir, v);
    total++; if (pc !== 32'h20) begin bad++; $display("[TB] FAIL trig_addr7 got=%h want=20", pc); end
    readEntry(4'd0, pc, ir, v);
    total++; if (pc !== 32'h4) begin bad++; $display("[TB] FAIL trig_addr0 got=%h want=4", pc); end
  endtask

  task automatic test_halt_and_arm();
    logic [31:0] pc, ir, r0;
    logic        v;
    doReset();
    applyStimulus(1'b1, 32'hFC, 32'h1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h100, 32'h2, 1'b0);
    total++; if (bus.halted_o !== 1'b0 || bus.state_o !== 2'd0) begin bad++; $display("[TB] FAIL halt_early got=%0b/%0d want=0/0", bus.halted_o, bus.state_o); end
    applyStimulus(1'b1, 32'h100, 32'h2, 1'b0);
    total++; if (bus.halted_o !== 1'b1 || bus.state_o !== 2'd2) begin bad++; $display("[TB] FAIL halt_set got=%0b/%0d want=1/2", bus.halted_o, bus.state_o); end
    total++; if (bus.count_o !== 5'd5) begin bad++; $display("[TB] FAIL halt_count got=%0d want=5", bus.count_o); end
    applyStimulus(1'b1, 32'h200, 32'h3, 1'b0);
    total++; if (bus.count_o !== 5'd5) begin bad++; $display("[TB] FAIL halt_frozen got=%0d want=5", bus.count_o); end
    r0 = bus.retired_o;
    applyStimulus(1'b1, 32'h500, 32'h5, 1'b1);
    total++; if (bus.state_o !== 2'd0 || bus.count_o !== 5'd0 || bus.halted_o !== 1'b0) begin bad++; $display("[TB] FAIL arm_clear got=%0d/%0d/%0b want=0/0/0", bus.state_o, bus.count_o, bus.halted_o); end
    total++; if (bus.retired_o !== r0 + 32'd1) begin bad++; $display("[TB] FAIL arm_retired got=%0d want=%0d", bus.retired_o, r0 + 32'd1); end
    applyStimulus(1'b1, 32'h600, 32'h6, 1'b0);
    readEntry(4'd0, pc, ir, v);
    total++; if (bus.count_o !== 5'd1 || pc !== 32'h600) begin bad++; $display("[TB] FAIL arm_first got=%0d/%h want=1/600", bus.count_o, pc); end
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h100, 32'h2, 1'b0);
    applyStimulus(1'b1, 32'h104, 32'h3, 1'b0);
    total++; if (bus.halted_o !== 1'b0 || bus.state_o !== 2'd0 || bus.count_o !== 5'd4) begin bad++; $display("[TB] FAIL no_halt got=%0b/%0d/%0d want=0/0/4", bus.halted_o, bus.state_o, bus.count_o); end
  endtask

`ifdef TRACE_CYCLE_EN
  task automatic test_cycle_stamp();
    logic [31:0] pc, ir;
    logic        v;
    int          budget;
    doReset();
    budget = 0;
    while (bus.cycle_o !== 32'd37 && budget < 100) begin
      step();
      budget++;
    end
    total++;
    if (bus.cycle_o !== 32'd37) begin
      bad++;
      $display("[TB] FAIL cycle_wait got=%0d want=37", bus.cycle_o);
    end else begin
      applyStimulus(1'b1, 32'h777, 32'h7, 1'b0);
      readEntry(4'd0, pc, ir, v);
      total++; if (bus.rd_cycle_o !== 32'd37 || pc !== 32'h777) begin bad++; $display("[TB] FAIL cycle_stamp got=%0d/%h want=37/777", bus.rd_cycle_o, pc); end
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.valid_i   = 1'b0;
    bus.pc_i      = '0;
    bus.ir_i      = '0;
    bus.arm_i     = 1'b0;
    bus.trig_en_i = 1'b0;
    bus.trig_pc_i = '0;
    bus.rd_en_i   = 1'b0;
    bus.rd_addr_i = '0;
    test_reset();
    test_wrap_and_back_to_back();
    test_trigger();
    test_halt_and_arm();
`ifdef TRACE_CYCLE_EN
    test_cycle_stamp();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
